// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame payload and baud divisor helper.
`timescale 1ns/1ps
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned CNT_W     = 16;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA       = 3'd2,
      PARITY     = 3'd3,
      STOP       = 3'd4,
      BREAK_WAIT = 3'd5
   } uart_state_e;

   typedef struct packed {
      logic [DATA_BITS-1:0] data;
      logic                 parity_err;
      logic                 frame_err;
   } rx_result_t;

   function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input pin.
`timescale 1ns/1ps
module uart_rx_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8E1 UART receiver: mid-bit sampling of a synchronized rx line, one-cycle valid pulse per frame.
`timescale 1ns/1ps
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD_RATE = 9600
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 rx_busy
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned IDX_W        = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;
   uart_state_e          state_q,     state_d;
   logic [CNT_W-1:0]     clk_count_q, clk_count_d;
   logic [IDX_W-1:0]     bit_index_q, bit_index_d;
   logic [DATA_BITS-1:0] shift_q,     shift_d;
   logic                 parity_q,    parity_d;
   rx_result_t           result_q,    result_d;
   logic                 rx_valid_q,  rx_valid_d;
   logic                 rx_busy_q,   rx_busy_d;

   uart_rx_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (rx),
      .q_o     (rx_s)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         clk_count_q <= '0;
         bit_index_q <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         result_q    <= '0;
         rx_valid_q  <= 1'b0;
         rx_busy_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clk_count_q <= clk_count_d;
         bit_index_q <= bit_index_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         result_q    <= result_d;
         rx_valid_q  <= rx_valid_d;
         rx_busy_q   <= rx_busy_d;
      end
   end

   // Counter restarts on every state change so each state measures from its own entry.
   always_comb begin
      state_d     = state_q;
      clk_count_d = clk_count_q + CNT_W'(1);
      bit_index_d = bit_index_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      result_d    = result_q;
      rx_valid_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            clk_count_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (clk_count_q == HALF_LAST) begin
               clk_count_d = '0;
               state_d     = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (clk_count_q == BIT_LAST) begin
               clk_count_d          = '0;
               shift_d[bit_index_q] = rx_s;
               if (bit_index_q == IDX_LAST) begin
                  bit_index_d = '0;
                  state_d     = PARITY;
               end else begin
                  bit_index_d = bit_index_q + IDX_W'(1);
               end
            end
         end
         PARITY: begin
            if (clk_count_q == BIT_LAST) begin
               clk_count_d = '0;
               parity_d    = rx_s;
               state_d     = STOP;
            end
         end
         STOP: begin
            // Leave at mid-stop-bit to keep margin for back-to-back frames.
            if (clk_count_q == BIT_LAST) begin
               clk_count_d         = '0;
               rx_valid_d          = 1'b1;
               result_d.data       = shift_q;
               result_d.parity_err = parity_q ^ (^shift_q);
               result_d.frame_err  = ~rx_s;
               state_d             = rx_s ? IDLE : BREAK_WAIT;
            end
         end
         BREAK_WAIT: begin
            clk_count_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            clk_count_d = '0;
            state_d     = IDLE;
         end
      endcase

      rx_busy_d = (state_d != IDLE);
   end

   assign data       = result_q.data;
   assign parity_err = result_q.parity_err;
   assign frame_err  = result_q.frame_err;
   assign rx_valid   = rx_valid_q;
   assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: line-level frame generator with a queue-based frame scoreboard.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int unsigned CLK_FREQ  = 1000000;
   localparam int unsigned BAUD_RATE = 100000;
   localparam int          CPB       = 10;
   localparam int          HALF      = CPB / 2;
   localparam int          LAT       = 2 + HALF + 10 * CPB + 1;
   localparam int          NOM_NS    = 100;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx;
   logic [7:0] data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       rx_busy;

   uart_rx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx         (rx),
      .data       (data),
      .rx_valid   (rx_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .rx_busy    (rx_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      bit         pe;
      bit         fe;
      int         start_cyc;
      bit         chk_lat;
   } exp_t;

   exp_t       exp_q[$];
   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   logic [7:0] last_d;
   bit         last_pe;
   bit         last_fe;
   bit         prev_v = 1'b0;
   int         last_lat = 0;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every valid pulse pops one expected frame; otherwise outputs must hold.
   always @(negedge clk) begin
      exp_t e;
      int   lat;
      if (!reset_n) begin
         chk(data === 8'h00 && rx_valid === 1'b0 && parity_err === 1'b0 &&
             frame_err === 1'b0 && rx_busy === 1'b0, "reset_outputs",
             int'({data, rx_valid, parity_err, frame_err, rx_busy}), 0);
         prev_v = 1'b0;
      end else begin
         if (rx_valid === 1'b1) begin
            chk(!prev_v, "valid_consecutive", 1, 0);
            if (exp_q.size() == 0) begin
               chk(1'b0, "spurious_valid", int'(data), 0);
            end else begin
               e   = exp_q.pop_front();
               lat = cyc - e.start_cyc;
               chk(data === e.d, "frame_data", int'(data), int'(e.d));
               chk(parity_err === e.pe, "frame_parity_err", int'(parity_err), int'(e.pe));
               chk(frame_err === e.fe, "frame_frame_err", int'(frame_err), int'(e.fe));
               if (e.chk_lat) chk(lat >= LAT - 1 && lat <= LAT + 1, "latency", lat, LAT);
               last_lat = lat;
               last_d   = e.d;
               last_pe  = e.pe;
               last_fe  = e.fe;
            end
         end else begin
            chk(data === last_d && parity_err === last_pe && frame_err === last_fe, "held",
                int'({data, parity_err, frame_err}), int'({last_d, last_pe, last_fe}));
         end
         prev_v = (rx_valid === 1'b1);
      end
   end

   task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                       input int bit_ns, input int hold_bits);
      exp_t e;
      logic par;
      par         = (^b) ^ bad_par;
      e.d         = b;
      e.pe        = bad_par;
      e.fe        = bad_stop;
      e.start_cyc = cyc;
      e.chk_lat   = (bit_ns == NOM_NS) && ($time % 10 == 0);
      exp_q.push_back(e);
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bit_ns);
      end
      rx = par;
      #(bit_ns);
      rx = ~bad_stop;
      #(bit_ns);
      if (bad_stop) begin
         #(hold_bits * bit_ns);
         chk(rx_busy === 1'b1, "busy_in_break", int'(rx_busy), 1);
         rx = 1'b1;
         repeat (5) @(negedge clk);
         chk(rx_busy === 1'b0, "busy_after_break", int'(rx_busy), 0);
      end
   endtask

   task automatic clear_model();
      exp_q.delete();
      last_d  = 8'h00;
      last_pe = 1'b0;
      last_fe = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      bit         bp;
      bit         bs;
      int         ns;
      int         gap;
      int         skews[3];
      skews = '{100, 97, 103};

      clear_model();
      reset_n = 1'b0;
      rx      = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk(rx_busy === 1'b0, "busy_idle_after_reset", int'(rx_busy), 0);

      // Good frame with latency pin
      send(8'hA5, 1'b0, 1'b0, NOM_NS, 0);
      repeat (5) @(negedge clk);
      chk(data === 8'hA5, "a5_data", int'(data), 32'hA5);
      chk(parity_err === 1'b0, "a5_parity_err", int'(parity_err), 0);
      chk(frame_err === 1'b0, "a5_frame_err", int'(frame_err), 0);
      chk(last_lat >= 107 && last_lat <= 109, "a5_latency", last_lat, 108);

      // Bad parity still delivers data
      send(8'h3C, 1'b1, 1'b0, NOM_NS, 0);
      repeat (5) @(negedge clk);
      chk(data === 8'h3C, "3c_data", int'(data), 32'h3C);
      chk(parity_err === 1'b1, "3c_parity_err", int'(parity_err), 1);
      chk(frame_err === 1'b0, "3c_frame_err", int'(frame_err), 0);

      // Stop bit low followed by a long break
      send(8'hFF, 1'b0, 1'b1, NOM_NS, 30);
      chk(data === 8'hFF, "ff_data", int'(data), 32'hFF);
      chk(frame_err === 1'b1, "ff_frame_err", int'(frame_err), 1);
      chk(parity_err === 1'b0, "ff_parity_err", int'(parity_err), 0);

      // Short glitch on idle line
      @(negedge clk);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      @(negedge clk);
      chk(rx_busy === 1'b1, "glitch_busy", int'(rx_busy), 1);
      repeat (20) @(negedge clk);
      chk(rx_busy === 1'b0, "glitch_idle", int'(rx_busy), 0);
      chk(data === 8'hFF, "glitch_data_held", int'(data), 32'hFF);
      chk(frame_err === 1'b1, "glitch_flag_held", int'(frame_err), 1);

      // Back-to-back bytes at nominal and skewed bit times
      foreach (skews[k]) begin
         @(negedge clk);
         send(8'h00, 1'b0, 1'b0, skews[k], 0);
         send(8'h55, 1'b0, 1'b0, skews[k], 0);
         send(8'hFF, 1'b0, 1'b0, skews[k], 0);
         repeat (10) @(negedge clk);
         chk(exp_q.size() == 0, "loop_drain", exp_q.size(), 0);
         chk(data === 8'hFF && frame_err === 1'b0 && parity_err === 1'b0, "loop_last",
             int'({data, parity_err, frame_err}), 32'h3FC);
      end

      // Reset in the middle of bit 4 abandons the frame
      @(negedge clk);
      rx = 1'b0;
      #(NOM_NS);
      for (int i = 0; i < 4; i++) begin
         rx = (i == 0);
         #(NOM_NS);
      end
      rx = 1'b0;
      #(NOM_NS / 2 + 3);
      clear_model();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk(rx_busy === 1'b0, "busy_after_abort", int'(rx_busy), 0);
      send(8'h81, 1'b0, 1'b0, NOM_NS, 0);
      repeat (5) @(negedge clk);
      chk(data === 8'h81, "81_data", int'(data), 32'h81);
      chk(parity_err === 1'b0 && frame_err === 1'b0, "81_flags",
          int'({parity_err, frame_err}), 0);

      // Randomized frames
      for (int n = 0; n < 40; n++) begin
         b   = 8'($urandom);
         bp  = ($urandom_range(0, 3) == 0);
         bs  = ($urandom_range(0, 7) == 0);
         ns  = int'($urandom_range(97, 103));
         gap = int'($urandom_range(0, 2));
         if (gap > 0) #(gap * ns);
         if ($urandom_range(0, 1) == 1) begin
            ns = NOM_NS;
            @(negedge clk);
         end
         send(b, bp, bs, ns, int'($urandom_range(2, 5)));
      end

      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      chk(exp_q.size() == 0, "final_drain", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
